// File: rtl/div_defs.sv
// Shared definitions for the restoring divider: state encoding, widths and
// the divide-by-zero quotient default.
package div_defs;

    localparam int              WIDTH_DEF     = 32;
    localparam int              ITER_COUNT    = 32;
    localparam int              CNT_W         = $clog2(ITER_COUNT);
    localparam logic [31:0]     DIV0_QUOT_DEF = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/Suber.sv
// Shared datapath subtractor: a - b with zero and sign flags.
module Suber #(
    parameter int W = 32
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] diff_o,
    output logic         zero_o,
    output logic         neg_o
);

    assign diff_o = a_i - b_i;
    assign zero_o = (diff_o == '0);
    assign neg_o  = diff_o[W-1];

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider (signed/unsigned), one quotient bit per cycle,
// sign fix-up after the iterations and a one-cycle done pulse with held results.
module div_sequencer
    import div_defs::*;
#(
    parameter int               WIDTH     = WIDTH_DEF,
    parameter logic [WIDTH-1:0] DIV0_QUOT = DIV0_QUOT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output state_t           dbg_state
);

    // Handshake: start is sampled only while busy is low (IDLE or DONE);
    // busy covers PREP..FIX, done pulses once with the results valid.
    state_t             state_q;
    logic               busy_q, done_q, dbz_q, sgn_q;
    logic [WIDTH-1:0]   quot_q, rem_q;
    logic [WIDTH-1:0]   a_q, b_q, d_q, r_q, q_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [WIDTH:0]     s_w;
    logic [WIDTH-1:0]   sub_diff;
    logic               ge_w;
    logic               sub_zero_unused, sub_neg_unused;

    assign s_w  = {r_q, q_q[WIDTH-1]};
    // The 33rd bit covers partial remainders that overflow 32 bits.
    assign ge_w = s_w[WIDTH] | (s_w[WIDTH-1:0] >= d_q);

    Suber #(.W(WIDTH)) u_sub (
        .a_i    (s_w[WIDTH-1:0]),
        .b_i    (d_q),
        .diff_o (sub_diff),
        .zero_o (sub_zero_unused),
        .neg_o  (sub_neg_unused)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            sgn_q   <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_q     <= dividend;
                        b_q     <= divisor;
                        sgn_q   <= signed_op;
                        busy_q  <= 1'b1;
                        state_q <= S_PREP;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_PREP: begin
                    if (b_q == '0) begin
                        quot_q  <= DIV0_QUOT;
                        rem_q   <= a_q;
                        dbz_q   <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        r_q     <= '0;
                        q_q     <= (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
                        d_q     <= (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
                        cnt_q   <= CNT_W'(ITER_COUNT - 1);
                        state_q <= S_ITER;
                    end
                end
                S_ITER: begin
                    r_q <= ge_w ? sub_diff : s_w[WIDTH-1:0];
                    q_q <= {q_q[WIDTH-2:0], ge_w};
                    if (cnt_q == '0) begin
                        state_q <= S_FIX;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_FIX: begin
                    quot_q  <= (sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -q_q : q_q;
                    rem_q   <= (sgn_q && a_q[WIDTH-1]) ? -r_q : r_q;
                    dbz_q   <= 1'b0;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_DONE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: vector table plus multi-cycle corner sequences.
module tb_div_sequencer;
  import div_defs::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  state_t      dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  div_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_q;
    logic [31:0] exp_r;
    logic        exp_dbz;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one request; returns the cycle (relative to acceptance at cycle 0)
  // at which done was seen, or -1 on timeout. poke_cyc injects a foreign start.
  task automatic run_op(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input int poke_cyc, output int lat, output logic busy1);
    int cyc;
    signed_op = sg;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 1;
    lat   = -1;
    busy1 = busy;
    while (cyc < 100 && lat < 0) begin
      if (done) begin
        lat = cyc;
      end else begin
        if (cyc == poke_cyc) begin
          start     = 1'b1;
          signed_op = 1'b0;
          dividend  = 32'd9;
          divisor   = 32'd3;
        end
        @(posedge clk); #1;
        start = 1'b0;
        cyc++;
      end
    end
  endtask

  task automatic check_result(input string tag, input vec_t v, input int lat, input logic busy1);
    chk({tag, " latency"}, lat, v.exp_lat);
    chk({tag, " busy_c1"}, {31'd0, busy1}, (v.exp_lat > 2 || !v.exp_dbz) ? 32'd1 : 32'd1);
    chk({tag, " quotient"}, quotient, v.exp_q);
    chk({tag, " remainder"}, remainder, v.exp_r);
    chk({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, v.exp_dbz});
    chk({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int   lat;
    logic b1;
    vec_t v;
    string tag;

    reset     = 1'b1;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = '0;
    divisor   = '0;

    vecs.push_back('{1'b0, 32'd100,        32'd7,        32'd14,        32'd2,         1'b0, 35});
    vecs.push_back('{1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 35});
    vecs.push_back('{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,        1'b0, 35});
    vecs.push_back('{1'b0, 32'hFFFF_FFFF,  32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b0, 35});
    vecs.push_back('{1'b0, 32'd5,          32'd0,        32'hFFFF_FFFF, 32'd5,         1'b1, 2});
    vecs.push_back('{1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0, 35});
    vecs.push_back('{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE, 1'b0, 35});
    vecs.push_back('{1'b0, 32'd0,          32'd3,        32'd0,         32'd0,         1'b0, 35});
    vecs.push_back('{1'b1, 32'hFFFF_FFF9,  32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 2});
    vecs.push_back('{1'b0, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF, 32'd0,         1'b0, 35});
    vecs.push_back('{1'b0, 32'h1234_5678,  32'd1000,     32'h0004_A90B, 32'd896,       1'b0, 35});

    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset quotient", quotient, 32'd0);
    chk("reset remainder", remainder, 32'd0);
    chk("reset div_by_zero", {31'd0, div_by_zero}, 32'd0);
    chk("reset state", 32'(dbg_state), 32'(S_IDLE));
    reset = 1'b0;
    @(posedge clk); #1;

    // table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      tag = $sformatf("vec%0d", i);
      run_op(v.sg, v.a, v.b, -1, lat, b1);
      check_result(tag, v, lat, b1);
      @(posedge clk); #1;
      chk({tag, " done_pulse"}, {31'd0, done}, 32'd0);
      chk({tag, " q_held"}, quotient, v.exp_q);
      chk({tag, " state_idle"}, 32'(dbg_state), 32'(S_IDLE));
    end

    // start in the DONE cycle is accepted; next done 35 cycles later
    v = vecs[0];
    run_op(v.sg, v.a, v.b, -1, lat, b1);
    check_result("b2b first", v, lat, b1);
    v = vecs[3];
    run_op(v.sg, v.a, v.b, -1, lat, b1);
    check_result("b2b second", v, lat, b1);
    @(posedge clk); #1;

    // foreign start during ITER is ignored
    v = vecs[0];
    run_op(v.sg, v.a, v.b, 5, lat, b1);
    check_result("poke iter", v, lat, b1);
    @(posedge clk); #1;

    // reset at cycle 10 (together with a start) abandons the op; restart at 12
    begin
      int cyc;
      int seen_done;
      seen_done = 0;
      signed_op = 1'b0;
      dividend  = 32'd100;
      divisor   = 32'd7;
      start     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc   = 1;
      while (cyc < 10) begin
        if (done) seen_done++;
        @(posedge clk); #1;
        cyc++;
      end
      reset    = 1'b1;
      start    = 1'b1;
      dividend = 32'd50;
      divisor  = 32'd3;
      @(posedge clk); #1;
      reset = 1'b0;
      start = 1'b0;
      if (done) seen_done++;
      chk("rst mid busy", {31'd0, busy}, 32'd0);
      chk("rst mid state", 32'(dbg_state), 32'(S_IDLE));
      chk("rst mid quotient", quotient, 32'd0);
      @(posedge clk); #1;
      if (done) seen_done++;
      chk("rst mid idle busy", {31'd0, busy}, 32'd0);
      chk("rst mid no done", seen_done, 32'd0);
      run_op(1'b0, 32'd1000, 32'd10, -1, lat, b1);
      chk("rst restart latency", 12 + lat, 32'd47);
      chk("rst restart quotient", quotient, 32'd100);
      chk("rst restart remainder", remainder, 32'd0);
      chk("rst restart dbz", {31'd0, div_by_zero}, 32'd0);
    end

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
